// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle for pc_gen. Trace signals exist only when PC_TRACE_EN is defined.
`default_nettype none

interface pc_gen_if #(
    parameter int WIDTH       = 32
`ifdef PC_TRACE_EN
    , parameter int TRACE_DEPTH = 8
`endif
);
    logic             hit;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_valid;
    logic [WIDTH-1:0] pc_out;
    logic             pc_valid;
    logic             redirect_pend;
    logic             misaligned;

`ifdef PC_TRACE_EN
    localparam int c_TW = $clog2(TRACE_DEPTH);
    logic [c_TW-1:0]  trace_idx;
    logic [WIDTH-1:0] trace_pc;
    logic [c_TW:0]    trace_count;

    modport master (
        output hit, redirect_valid, redirect_target, exc_valid, trace_idx,
        input  pc_out, pc_valid, redirect_pend, misaligned, trace_pc, trace_count
    );
    modport slave (
        input  hit, redirect_valid, redirect_target, exc_valid, trace_idx,
        output pc_out, pc_valid, redirect_pend, misaligned, trace_pc, trace_count
    );
`else
    modport master (
        output hit, redirect_valid, redirect_target, exc_valid,
        input  pc_out, pc_valid, redirect_pend, misaligned
    );
    modport slave (
        input  hit, redirect_valid, redirect_target, exc_valid,
        output pc_out, pc_valid, redirect_pend, misaligned
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
//------------------------------------------------------------------------------
// pc_gen : fetch program-counter generator (step / redirect / exception vector,
//          stall on I-cache miss, held redirect). Optional PC trace ring: PC_TRACE_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_gen #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int               STEP         = 4,
    parameter int               ALIGN_BITS   = 2
`ifdef PC_TRACE_EN
    , parameter int             TRACE_DEPTH  = 8
`endif
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_STEP       = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_valid;
    logic             r_pend;
    logic             r_mis;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_next_target;

    always_comb begin
        w_next_state  = r_state;
        w_next_pc     = r_pc;
        w_next_target = r_pend_target;
        if (r_state == S_BOOT) begin
            w_next_state = S_RUN;
        end else begin
            // Unreachable encodings fall back to RUN
            w_next_state = (r_state == S_PEND) ? S_PEND : S_RUN;
            if (bus.exc_valid) begin
                w_next_pc    = EXC_VECTOR;
                w_next_state = S_RUN;
            end else if (bus.redirect_valid && bus.hit) begin
                w_next_pc    = bus.redirect_target;
                w_next_state = S_RUN;
            end else if (bus.redirect_valid) begin
                w_next_target = bus.redirect_target;
                w_next_state  = S_PEND;
            end else if (bus.hit && r_state == S_PEND) begin
                w_next_pc    = r_pend_target;
                w_next_state = S_RUN;
            end else if (bus.hit) begin
                w_next_pc = r_pc + c_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend_target <= '0;
            r_valid       <= 1'b0;
            r_pend        <= 1'b0;
            r_mis         <= |(RESET_VECTOR & c_ALIGN_MASK);
        end else begin
            r_state       <= w_next_state;
            r_pc          <= w_next_pc;
            r_pend_target <= w_next_target;
            r_valid       <= 1'b1;
            r_pend        <= (w_next_state == S_PEND);
            r_mis         <= |(w_next_pc & c_ALIGN_MASK);
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.pc_valid      = r_valid;
    assign bus.redirect_pend = r_pend;
    assign bus.misaligned    = r_mis;

`ifdef PC_TRACE_EN
    localparam int              c_TW   = $clog2(TRACE_DEPTH);
    localparam logic [c_TW:0]   c_FULL = (c_TW+1)'(TRACE_DEPTH);

    logic [WIDTH-1:0] r_ring [TRACE_DEPTH];
    logic [c_TW-1:0]  r_wr_ptr;
    logic [c_TW:0]    r_count;
    logic [c_TW-1:0]  w_rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                r_ring[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (r_state != S_BOOT && bus.hit) begin
            r_ring[r_wr_ptr] <= r_pc;
            r_wr_ptr         <= r_wr_ptr + c_TW'(1);
            if (r_count != c_FULL) begin
                r_count <= r_count + (c_TW+1)'(1);
            end
        end
    end

    // Index 0 is the entry written most recently, one behind the write pointer
    assign w_rd_ptr        = r_wr_ptr - c_TW'(1) - bus.trace_idx;
    assign bus.trace_pc    = ({1'b0, bus.trace_idx} < r_count) ? r_ring[w_rd_ptr] : '0;
    assign bus.trace_count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//------------------------------------------------------------------------------
// tb_pc_gen : directed literal checks plus randomized run against a behavioural model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_gen;
    localparam int W  = 32;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(W)
`ifdef PC_TRACE_EN
        , .TRACE_DEPTH(TD)
`endif
    ) bus ();

    pc_gen #(
        .WIDTH(W), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .STEP(4), .ALIGN_BITS(2)
`ifdef PC_TRACE_EN
        , .TRACE_DEPTH(TD)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: booted flag, pending flag + target, queue of traced PCs
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_valid, m_pend, m_boot;
    logic [31:0] m_tr[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h0; m_tgt = 32'h0; m_valid = 0; m_pend = 0; m_boot = 1;
            m_tr.delete();
        end else if (m_boot) begin
            m_boot = 0; m_valid = 1;
        end else begin
            if (bus.hit) begin
                m_tr.push_front(m_pc);
                if (m_tr.size() > TD) void'(m_tr.pop_back());
            end
            if (bus.exc_valid) begin
                m_pc = 32'h80; m_pend = 0;
            end else if (bus.redirect_valid && bus.hit) begin
                m_pc = bus.redirect_target; m_pend = 0;
            end else if (bus.redirect_valid) begin
                m_tgt = bus.redirect_target; m_pend = 1;
            end else if (bus.hit) begin
                m_pc   = m_pend ? m_tgt : m_pc + 32'd4;
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_out", bus.pc_out, m_pc);
            chk("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
            chk("redirect_pend", 32'(bus.redirect_pend), 32'(m_pend));
            chk("misaligned", 32'(bus.misaligned), 32'(m_pc[1:0] != 2'b00));
`ifdef PC_TRACE_EN
            chk("trace_count", 32'(bus.trace_count), m_tr.size());
            chk("trace_pc", bus.trace_pc,
                (int'(bus.trace_idx) < m_tr.size()) ? m_tr[bus.trace_idx] : 32'h0);
`endif
        end
    end

    task automatic drive(input logic h, input logic rv, input logic [31:0] t, input logic e);
        bus.hit = h; bus.redirect_valid = rv; bus.redirect_target = t; bus.exc_valid = e;
    endtask

    task automatic cyc(input logic h, input logic rv, input logic [31:0] t, input logic e);
        @(negedge clk); #1;
        drive(h, rv, t, e);
        @(posedge clk); #1;
    endtask

    task automatic exp_pc(string name, logic [31:0] pc, logic pend);
        chk({name, ".pc"}, bus.pc_out, pc);
        chk({name, ".pend"}, 32'(bus.redirect_pend), 32'(pend));
    endtask

    initial begin
`ifdef PC_TRACE_EN
        logic [31:0] exp_tr[4];
        exp_tr = '{32'h14, 32'h10, 32'h0C, 32'h08};
        bus.trace_idx = '0;
`endif
        drive(0, 0, 32'h0, 0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.pc", bus.pc_out, 32'h0);
        chk("reset.valid", 32'(bus.pc_valid), 32'h0);
        chk("reset.pend", 32'(bus.redirect_pend), 32'h0);
        chk_en = 1;

        // Boot then sequential stepping
        #1 rst = 1'b0; bus.hit = 1'b1;
        @(posedge clk); #1;
        exp_pc("boot", 32'h0, 0);
        chk("boot.valid", 32'(bus.pc_valid), 32'h1);
        cyc(1, 0, 0, 0); exp_pc("seq1", 32'h4, 0);
        cyc(1, 0, 0, 0); exp_pc("seq2", 32'h8, 0);
        cyc(1, 0, 0, 0); exp_pc("seq3", 32'hC, 0);
        // Stall
        repeat (3) begin cyc(0, 0, 0, 0); exp_pc("stall", 32'hC, 0); end
        // Redirect during stall is held
        cyc(0, 1, 32'h100, 0); exp_pc("pend0", 32'hC, 1);
        cyc(0, 0, 0, 0);       exp_pc("pend1", 32'hC, 1);
        cyc(0, 0, 0, 0);       exp_pc("pend2", 32'hC, 1);
        cyc(1, 0, 0, 0);       exp_pc("pend_go", 32'h100, 0);
        cyc(1, 0, 0, 0);       exp_pc("pend_seq", 32'h104, 0);
        // Exception beats held and simultaneous redirect
        cyc(0, 1, 32'h200, 0);  exp_pc("pend200", 32'h104, 1);
        cyc(0, 1, 32'h300, 1);  exp_pc("exc", 32'h80, 0);
        cyc(1, 0, 0, 0);        exp_pc("exc_seq", 32'h84, 0);
        // Wrap and misalignment
        cyc(1, 1, 32'hFFFF_FFFC, 0); exp_pc("top", 32'hFFFF_FFFC, 0);
        cyc(1, 0, 0, 0);             exp_pc("wrap", 32'h0, 0);
        cyc(1, 1, 32'h102, 0);       exp_pc("mis", 32'h102, 0);
        chk("mis.flag", 32'(bus.misaligned), 32'h1);
        cyc(1, 0, 0, 0);
        chk("mis.step", bus.pc_out, 32'h106);
        chk("mis.flag2", 32'(bus.misaligned), 32'h1);

`ifdef PC_TRACE_EN
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0; drive(1, 0, 0, 0);
        @(posedge clk); #1;
        repeat (6) cyc(1, 0, 0, 0);
        chk("trace.count", 32'(bus.trace_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            bus.trace_idx = 2'(i);
            #1 chk("trace.entry", bus.trace_pc, exp_tr[i]);
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("async.pc", bus.pc_out, 32'h0);
        chk("async.count", 32'(bus.trace_count), 32'h0);
        bus.trace_idx = 2'd1;
        #1 chk("async.trace_pc", bus.trace_pc, 32'h0);
        @(negedge clk); #1 rst = 1'b0;
`endif

        // Randomized run with occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 15,
                  ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                  $urandom_range(0, 99) < 5);
            @(posedge clk); #1;
`ifdef PC_TRACE_EN
            bus.trace_idx = 2'($urandom_range(0, TD - 1));
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
